alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational integer ALU between two requesters, for example the integer pipeline and the address-generation or multiply-assist path. Each request is accepted with a valid/ready handshake. The arbiter drives the ALU operand and control inputs for the winning requester, registers the ALU result and zero flag, and returns them on a per-requester response channel. Arbitration is round-robin, and at most one operation is in flight at a time.

## Interface
- REGSIZE, 64, datapath width; matches the ALU's REGSIZE.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; one-hot or zero.
- req_a0, req_b0  input  REGSIZE  requester 0 operands.
- req_a1, req_b1  input  REGSIZE  requester 1 operands.
- req_ctl0, req_ctl1  input  4  ALU control codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB. Any other code yields a result of 0.
- alu_in1, alu_in2  output  REGSIZE  ALU operands (combinational).
- alu_ctl  output  4  ALU control (combinational).
- alu_result  input  REGSIZE  ALU result.
- alu_zero  input  1  ALU zero flag.
- resp_valid  output  2  per-requester response valid; one-hot or zero.
- resp_ready  input  2  per-requester response accept.
- resp_result  output  REGSIZE  registered result; only meaningful while a resp_valid bit is high.
- resp_zero  output  1  registered zero flag.

## Operation
- The FSM has two states, IDLE and RESP. Registered state:
  - state
  - last (index of the most recent grant)
  - gnt (the requester being served)
  - resp_result
  - resp_zero
- Grant selection in IDLE:
  - If exactly one req_valid bit is set, that requester wins.
  - If both are set, the requester not equal to last wins.
  - If neither is set, there is no grant.
- IDLE with a grant g:
  - alu_in1, alu_in2 and alu_ctl come from requester g's inputs.
  - req_ready[g] = 1 combinationally.
  - On the clock edge: resp_result ← alu_result, resp_zero ← alu_zero, gnt ← g, last ← g, state ← RESP.
- IDLE with no grant: alu_in1 = alu_in2 = 0, alu_ctl = 0000, req_ready = 00.
- RESP:
  - resp_valid[gnt] = 1, req_ready = 00, ALU inputs held at zero.
  - When resp_ready[gnt] is high, the FSM moves to IDLE on that edge.
  - resp_ready on the non-granted bit is ignored.
- Widths: results are passed through unmodified at REGSIZE bits; the arbiter performs no arithmetic of its own.
- Unsupported ctl codes are not checked. They are forwarded to the ALU and return result 0 with zero = 1.
- Requesters must hold their operands stable while valid is high. The arbiter samples them only in the accept cycle.

## Timing
- Reset values:
  - state = IDLE, last = 1 (requester 0 wins the first contention), gnt = 0.
  - resp_result = 0, resp_zero = 0, resp_valid = 00, req_ready = 00.
  - alu_in1 = alu_in2 = 0, alu_ctl = 0000.
- Latency: the accept happens in cycle N and resp_valid is high from cycle N+1.
- Throughput: at best one operation every 2 cycles, i.e. accept then response handshake. No new accept occurs in the cycle of the response handshake.
- Back-pressure: resp_valid, resp_result and resp_zero stay stable until resp_ready[gnt] is high.
- Simultaneous requests: the grant alternates strictly while both requesters keep valid high.
- A request arriving during RESP waits and is considered in the next IDLE cycle.
- rst_n asserted mid-operation: everything returns to reset values immediately and asynchronously. Any pending response is dropped.
- Deassertion of rst_n is assumed synchronized externally.

## Configuration
- ALU_ARB_STATS_EN defined:
  - Adds outputs stat_grant0 and stat_grant1, each 32 bits.
  - Each counts accepts for its requester and saturates at 0xFFFFFFFF.
  - Both reset to 0.
- ALU_ARB_STATS_EN not defined:
  - These ports and their counters are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then requester 0 sends ADD a=5, b=7 with resp_ready held at 01:
  - req_ready = 01 in the accept cycle.
  - Next cycle: resp_valid = 01, resp_result = 12, resp_zero = 0.
  - The cycle after: IDLE.
- Both requesters valid continuously, requester 0 SUB 3-3, requester 1 OR 0xF0|0x0F, resp_ready = 11:
  - Grant order is 0, 1, 0, 1.
  - Responses alternate between result 0/zero 1 and 0xFF/zero 0.
  - One accept every 2 cycles.
- Requester 1 AND 0xFF&0x0F with resp_ready held 00 for 4 cycles:
  - resp_valid = 10 and resp_result = 0x0F are stable for all 4 cycles.
  - Requester 0's valid is not accepted during that time.
- Requester 0 ctl = 1111:
  - Response result = 0, resp_zero = 1.
- rst_n pulsed low during RESP:
  - resp_valid drops to 00 immediately.
  - After release, simultaneous requests grant requester 0 first.
- With ALU_ARB_STATS_EN: after 3 requester-0 accepts and 2 requester-1 accepts, stat_grant0 = 3 and stat_grant1 = 2.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// one operation in flight. Define ALU_ARB_STATS_EN to add per-requester grant counters.
module alu_arbiter #(
    parameter int REGSIZE = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [REGSIZE-1:0] req_a0,
    input  logic [REGSIZE-1:0] req_b0,
    input  logic [REGSIZE-1:0] req_a1,
    input  logic [REGSIZE-1:0] req_b1,
    input  logic [3:0]         req_ctl0,
    input  logic [3:0]         req_ctl1,
    output logic [REGSIZE-1:0] alu_in1,
    output logic [REGSIZE-1:0] alu_in2,
    output logic [3:0]         alu_ctl,
    input  logic [REGSIZE-1:0] alu_result,
    input  logic               alu_zero,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [REGSIZE-1:0] resp_result,
    output logic               resp_zero
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [31:0]        stat_grant0,
    output logic [31:0]        stat_grant1
`endif
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t state;
    logic   last;
    logic   gnt;
    logic   grant_any;
    logic   grant_idx;

    // On contention the requester that did not win last time goes first.
    always_comb begin
        grant_any = (state == IDLE) && (req_valid != 2'b00);
        grant_idx = (req_valid == 2'b11) ? ~last : req_valid[1];
    end

    always_comb begin
        req_ready = 2'b00;
        alu_in1   = '0;
        alu_in2   = '0;
        alu_ctl   = 4'b0000;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
            alu_in1 = grant_idx ? req_a1   : req_a0;
            alu_in2 = grant_idx ? req_b1   : req_b0;
            alu_ctl = grant_idx ? req_ctl1 : req_ctl0;
        end
    end

    always_comb begin
        resp_valid = 2'b00;
        if (state == RESP) begin
            resp_valid[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            gnt         <= 1'b0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        resp_result <= alu_result;
                        resp_zero   <= alu_zero;
                        gnt         <= grant_idx;
                        last        <= grant_idx;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[gnt]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grant0 <= '0;
            stat_grant1 <= '0;
        end else if (grant_any) begin
            if (grant_idx) begin
                stat_grant1 <= sat_inc(stat_grant1);
            end else begin
                stat_grant0 <= sat_inc(stat_grant0);
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] a [2];
    logic [63:0] b [2];
    logic [3:0]  c [2];
    logic [63:0] alu_in1, alu_in2, alu_result;
    logic [3:0]  alu_ctl;
    logic        alu_zero;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [63:0] resp_result;
    logic        resp_zero;
`ifdef ALU_ARB_STATS_EN
    logic [31:0] stat_grant0, stat_grant1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.REGSIZE(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(a[0]), .req_b0(b[0]), .req_a1(a[1]), .req_b1(b[1]),
        .req_ctl0(c[0]), .req_ctl1(c[1]),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctl(alu_ctl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_zero(resp_zero)
`ifdef ALU_ARB_STATS_EN
        , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1)
`endif
    );

    function automatic logic [64:0] ref_alu(input logic [63:0] x, input logic [63:0] y,
                                            input logic [3:0] op);
        logic [63:0] r;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            default: r = 64'd0;
        endcase
        return {r == 64'd0, r};
    endfunction

    // Requester that wins this cycle, or -1 when nobody is granted.
    function automatic int pick(input logic [1:0] v, input logic prev);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return 1 - int'(prev);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // External ALU stub
    always_comb {alu_zero, alu_result} = ref_alu(alu_in1, alu_in2, alu_ctl);

    // Transaction-level model: one pending response at a time
    logic        m_busy, m_who, m_last, m_zero;
    logic [63:0] m_res;
    logic [1:0]  m_acc;
    int          m_win;
    int          cnt0, cnt1;
    int          cyc = 0;
    int          grant_log[$];
    int          acc_cyc[$];

    always_comb m_win = m_busy ? -1 : pick(req_valid, m_last);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_who <= 1'b0; m_last <= 1'b1;
            m_res <= 64'd0; m_zero <= 1'b0; m_acc <= 2'b00;
            cnt0 <= 0; cnt1 <= 0;
        end else begin
            m_acc <= 2'b00;
            if (m_win >= 0) begin
                m_busy <= 1'b1;
                m_who  <= 1'(m_win);
                m_last <= 1'(m_win);
                {m_zero, m_res} <= ref_alu(a[m_win], b[m_win], c[m_win]);
                m_acc  <= (m_win == 0) ? 2'b01 : 2'b10;
                if (m_win == 0) cnt0 <= cnt0 + 1; else cnt1 <= cnt1 + 1;
                grant_log.push_back(m_win);
                acc_cyc.push_back(cyc);
            end else if (m_busy && resp_ready[m_who]) begin
                m_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("req_ready", {62'd0, req_ready},
                m_win < 0 ? 64'd0 : (m_win == 0 ? 64'd1 : 64'd2));
            chk("alu_in1", alu_in1, m_win < 0 ? 64'd0 : a[m_win]);
            chk("alu_in2", alu_in2, m_win < 0 ? 64'd0 : b[m_win]);
            chk("alu_ctl", {60'd0, alu_ctl}, m_win < 0 ? 64'd0 : {60'd0, c[m_win]});
            chk("resp_valid", {62'd0, resp_valid},
                !m_busy ? 64'd0 : (m_who ? 64'd2 : 64'd1));
            if (m_busy) begin
                chk("resp_result", resp_result, m_res);
                chk("resp_zero", {63'd0, resp_zero}, {63'd0, m_zero});
            end
`ifdef ALU_ARB_STATS_EN
            chk("stat_grant0", {32'd0, stat_grant0}, 64'(cnt0));
            chk("stat_grant1", {32'd0, stat_grant1}, 64'(cnt1));
`endif
        end
    end

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 2'b00; resp_ready = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc1();
    endtask

    logic [1:0]  t2_v[$];
    logic [63:0] t2_r[$];
    logic        t2_z[$];

    initial begin
        req_valid = 2'b00; resp_ready = 2'b00;
        for (int i = 0; i < 2; i++) begin a[i] = 0; b[i] = 0; c[i] = 0; end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
        chk("rst_alu_in1", alu_in1, 64'd0);
        chk("rst_alu_ctl", {60'd0, alu_ctl}, 64'd0);
        chk("rst_resp_result", resp_result, 64'd0);
        chk("rst_resp_zero", {63'd0, resp_zero}, 64'd0);
        @(posedge clk); #2 rst_n = 1'b1; chk_en = 1'b1;
        cyc1();

        // Single ADD from requester 0
        a[0] = 5; b[0] = 7; c[0] = 4'b0010; req_valid = 2'b01; resp_ready = 2'b01;
        #3 chk("t1_req_ready", {62'd0, req_ready}, 64'd1);
        cyc1(); req_valid = 2'b00;
        #3 chk("t1_resp_valid", {62'd0, resp_valid}, 64'd1);
        chk("t1_resp_result", resp_result, 64'd12);
        chk("t1_resp_zero", {63'd0, resp_zero}, 64'd0);
        cyc1();
        #3 chk("t1_idle", {62'd0, resp_valid}, 64'd0);
        cyc1();

        // Both requesters continuously valid
        do_reset();
        grant_log.delete(); acc_cyc.delete();
        a[0] = 3; b[0] = 3; c[0] = 4'b0110;
        a[1] = 64'hF0; b[1] = 64'h0F; c[1] = 4'b0001;
        req_valid = 2'b11; resp_ready = 2'b11;
        for (int i = 0; i < 8; i++) begin
            #3;
            if (resp_valid != 2'b00) begin
                t2_v.push_back(resp_valid); t2_r.push_back(resp_result); t2_z.push_back(resp_zero);
            end
            cyc1();
        end
        chk("t2_grants", 64'(grant_log.size()), 64'd4);
        chk("t2_resps", 64'(t2_v.size()), 64'd4);
        if (grant_log.size() >= 4 && t2_v.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t2_grant_order", 64'(grant_log[i]), 64'(i % 2));
                chk("t2_resp_valid", {62'd0, t2_v[i]}, (i % 2 == 0) ? 64'd1 : 64'd2);
                chk("t2_resp_result", t2_r[i], (i % 2 == 0) ? 64'd0 : 64'hFF);
                chk("t2_resp_zero", {63'd0, t2_z[i]}, (i % 2 == 0) ? 64'd1 : 64'd0);
            end
            for (int i = 0; i < 3; i++)
                chk("t2_spacing", 64'(acc_cyc[i+1] - acc_cyc[i]), 64'd2);
        end
        req_valid = 2'b00;
        repeat (3) cyc1();

        // Back-pressure on requester 1 while requester 0 waits
        a[1] = 64'hFF; b[1] = 64'h0F; c[1] = 4'b0000; req_valid = 2'b10; resp_ready = 2'b00;
        cyc1();
        a[0] = 1; b[0] = 2; c[0] = 4'b0010; req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            #3;
            chk("t3_resp_valid", {62'd0, resp_valid}, 64'd2);
            chk("t3_resp_result", resp_result, 64'h0F);
            chk("t3_req_ready", {62'd0, req_ready}, 64'd0);
            cyc1();
        end
        resp_ready = 2'b01;
        #3 chk("t3_wrong_ready", {62'd0, resp_valid}, 64'd2);
        cyc1();
        resp_ready = 2'b10;
        cyc1();
        #3 chk("t3_req0_accept", {62'd0, req_ready}, 64'd1);
        resp_ready = 2'b11;
        cyc1(); req_valid = 2'b00;
        repeat (2) cyc1();

        // Unsupported control code
        a[0] = 5; b[0] = 9; c[0] = 4'b1111; req_valid = 2'b01;
        cyc1(); req_valid = 2'b00;
        #3 chk("t4_result", resp_result, 64'd0);
        chk("t4_zero", {63'd0, resp_zero}, 64'd1);
        repeat (2) cyc1();

        // Asynchronous reset during RESP
        a[0] = 1; b[0] = 1; c[0] = 4'b0010; req_valid = 2'b01; resp_ready = 2'b00;
        cyc1(); req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1 chk("t5_resp_valid", {62'd0, resp_valid}, 64'd0);
        chk("t5_resp_result", resp_result, 64'd0);
        req_valid = 2'b11; a[1] = 4; b[1] = 4; c[1] = 4'b0110;
        @(posedge clk); #2 rst_n = 1'b1;
        #2 chk("t5_first_grant", {62'd0, req_ready}, 64'd1);
        resp_ready = 2'b11;
        cyc1(); req_valid = 2'b00;
        repeat (2) cyc1();

`ifdef ALU_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 5; k++) begin
            req_valid = (k < 3) ? 2'b01 : 2'b10; resp_ready = 2'b11;
            cyc1(); req_valid = 2'b00;
            cyc1();
        end
        chk("stat0_lit", {32'd0, stat_grant0}, 64'd3);
        chk("stat1_lit", {32'd0, stat_grant1}, 64'd2);
`endif

        // Randomized traffic, requests held until accepted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_acc[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
                    req_valid[i] = 1'b1;
                    a[i] = {$urandom, $urandom};
                    case ($urandom_range(0, 3))
                        0: b[i] = a[i];
                        1: b[i] = 64'($urandom_range(0, 15));
                        2: b[i] = '1;
                        default: b[i] = {$urandom, $urandom};
                    endcase
                    case ($urandom_range(0, 4))
                        0: c[i] = 4'b0000;
                        1: c[i] = 4'b0001;
                        2: c[i] = 4'b0010;
                        3: c[i] = 4'b0110;
                        default: c[i] = 4'($urandom);
                    endcase
                end
            end
            resp_ready = 2'($urandom_range(0, 3));
            cyc1();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
